arc4_enc: RTL and testbench
===========================

Name: arc4_enc

Overview:
- ARC4 encryptor; the transmit-side counterpart of the ARC4 decryptor.
- Reads a length-prefixed plaintext from pt_mem and runs KSA and PRGA against an external 256x8 S memory.
- Writes the length-prefixed ciphertext into ct_mem, producing the images the decrypt/crack engines consume.

Parameters:
- KEY_BYTES, 3, key length in bytes; key port width is 8*KEY_BYTES.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  start request; sampled only while rdy=1.
- rdy  out  1  1 = idle and able to accept en.
- key  in  8*KEY_BYTES  key; byte 0 = most-significant byte; sampled on the accepting cycle.
- pt_addr  out  8  plaintext memory address.
- pt_rddata  in  8  plaintext data, valid 1 cycle after pt_addr.
- ct_addr  out  8  ciphertext memory address.
- ct_wrdata  out  8  ciphertext write data.
- ct_wren  out  1  ciphertext write strobe.
- s_addr  out  8  S memory address.
- s_rddata  in  8  S data, valid 1 cycle after s_addr.
- s_wrdata  out  8  S write data.
- s_wren  out  1  S write strobe.

Behaviour:
- Reset values: rdy=1, all *_wren=0, all addresses and wrdata=0, FSM=IDLE, i=j=k=0.
- Reset mid-operation aborts immediately; partially written memories are left as they are.
- Handshake: en=1 while rdy=1 latches key; rdy=0 from the next cycle.
- en while rdy=0 is ignored. No second request is queued.
- States: IDLE -> INIT -> KSA -> LEN -> PRGA -> DONE -> IDLE.
- INIT: S[i]=i for i=0..255, one write per cycle (256 cycles).
- KSA, for i=0..255:
  - read S[i], wait 1 cycle;
  - j = (j + S[i] + key[i mod KEY_BYTES]) mod 256;
  - read S[j], wait 1 cycle;
  - write S[i]=old S[j] and S[j]=old S[i] on two separate cycles.
  - When i==j the second write must leave the original value.
- LEN: read pt[0] = L; write ct[0] = L unencrypted. L=0 skips PRGA.
- PRGA: i=j=0. For k=1..L:
  - i=i+1; read S[i]; j=j+S[i]; read S[j]; swap as in KSA;
  - read S[(S[i]+S[j]) mod 256] = pad; read pt[k];
  - write ct[k] = pt[k] XOR pad.
- Arithmetic: all index arithmetic is 8-bit and wraps mod 256. k is 9-bit internally so L=255 terminates cleanly; maximum address used is 255.
- Strobes: at most one write strobe per memory per cycle. ct_wren and s_wren are each one-cycle pulses aligned with their address and data.
- DONE: rdy=1 on the cycle after the last ct write. Memories hold results; S keeps its final state.
- Back-to-back: en held high re-accepts in the first rdy=1 cycle. INIT fully re-initialises S.

Optional Feature:
- Macro: ARC4_ENC_DROP_EN.
- Defined: after KSA and before LEN, run 256 PRGA iterations (i/j update and swap, pad discarded, no ct writes), giving RC4-drop[256]. The PRGA phase then continues from that i/j, not from 0.
- Undefined: no drop phase; standard RC4, interoperable with the existing arc4 decryptor.

Test Plan:
- Known vector (macro off): key=24'h4B6579 ("Key"), pt = 09 "Plaintext" -> ct[0..9] = 09 BB F3 16 E8 D9 40 AF 0A D3; rdy returns to 1.
- Round trip: encrypt random 200-byte message with key=24'h1E4600, decrypt ct_mem with arc4 -> pt_mem image equals original bytes 0..200.
- L=0: pt[0]=00 -> exactly one ct write (ct[0]=00), no ct_wren for addr>=1; rdy=1 after KSA plus LEN.
- L=255, key=24'hFFFFFF: 256 ct writes, addresses 0..255 each written once, no wrap to address 0 after 255; matches software model.
- Reset at cycle 300 of KSA: rdy=1 and strobes=0 the cycle after rst; a fresh en with key=24'h4B6579 yields the known-vector ct. en pulsed while busy produces no extra run.
- Macro on: key=24'h4B6579, pt = 01 00 -> ct[1] equals the 257th keystream byte from the software model; no ct writes during the drop phase.

Source files
------------

// File: rtl/arc4_enc.sv
// arc4_enc: ARC4 (RC4) encryptor.
//
// Reads a length-prefixed plaintext from pt_mem and runs KSA and PRGA against
// an external 256x8 S memory. The length-prefixed ciphertext is written to
// ct_mem. Byte 0 of ct_mem is the length, copied through unencrypted.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   en         start request, sampled only while rdy=1
//   rdy        1 = idle and able to accept en
//   key        8*KEY_BYTES key, byte 0 is the most-significant byte
//   pt_addr    plaintext address; pt_rddata valid one cycle later
//   ct_addr    ciphertext address, with ct_wrdata / ct_wren
//   s_addr     S memory address; s_rddata valid one cycle later
//   s_wrdata   S write data, s_wren write strobe
//
// Build option:
//   ARC4_ENC_DROP_EN  when defined, 256 keystream bytes are discarded after
//                     KSA (RC4-drop[256]); PRGA continues from that i/j.
//
// state            | meaning
// -----------------+--------------------------------------------------
// S_IDLE           | rdy=1, waiting for en
// S_INIT           | S[i]=i, one write per cycle
// S_KSA_RD_I       | address S[i]
// S_KSA_WAIT_I     | S[i] read latency
// S_KSA_RD_J       | capture S[i], update j, address S[j]
// S_KSA_WAIT_J     | S[j] read latency
// S_KSA_WR_I       | write S[i]=old S[j]
// S_KSA_WR_J       | write S[j]=old S[i], advance i
// S_LEN_RD         | address pt[0]
// S_LEN_WAIT       | pt read latency
// S_LEN_WR         | ct[0]=L
// S_PRGA_RD_I      | i=i+1, address S[i]
// S_PRGA_WAIT_I    | S[i] read latency
// S_PRGA_RD_J      | capture S[i], update j, address S[j]
// S_PRGA_WAIT_J    | S[j] read latency
// S_PRGA_WR_I      | write S[i]=old S[j]
// S_PRGA_WR_J      | write S[j]=old S[i]
// S_PRGA_RD_PAD    | address S[S[i]+S[j]] and pt[k]
// S_PRGA_WAIT_PAD  | pad / pt read latency
// S_PRGA_WR_CT     | ct[k]=pt[k]^pad
// S_DONE           | raise rdy

module arc4_enc #(
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [7:0]             pt_addr,
  input  logic [7:0]             pt_rddata,
  output logic [7:0]             ct_addr,
  output logic [7:0]             ct_wrdata,
  output logic                   ct_wren,
  output logic [7:0]             s_addr,
  input  logic [7:0]             s_rddata,
  output logic [7:0]             s_wrdata,
  output logic                   s_wren
);

  typedef enum logic [4:0] {
    S_IDLE,
    S_INIT,
    S_KSA_RD_I,
    S_KSA_WAIT_I,
    S_KSA_RD_J,
    S_KSA_WAIT_J,
    S_KSA_WR_I,
    S_KSA_WR_J,
    S_LEN_RD,
    S_LEN_WAIT,
    S_LEN_WR,
    S_PRGA_RD_I,
    S_PRGA_WAIT_I,
    S_PRGA_RD_J,
    S_PRGA_WAIT_J,
    S_PRGA_WR_I,
    S_PRGA_WR_J,
    S_PRGA_RD_PAD,
    S_PRGA_WAIT_PAD,
    S_PRGA_WR_CT,
    S_DONE
  } state_t;

  state_t                 state;
  logic [7:0]             i;
  logic [7:0]             j;
  logic [8:0]             k;
  logic [7:0]             si;
  logic [7:0]             sj;
  logic [7:0]             len;
  logic [8*KEY_BYTES-1:0] key_r;
`ifdef ARC4_ENC_DROP_EN
  logic                   dropping;
`endif

  logic [7:0] key_byte;
  logic [7:0] i_next;
  logic [7:0] j_ksa;
  logic [7:0] j_prga;

  // The key register is rotated left one byte per KSA step, so the byte in
  // the top position is always key[i mod KEY_BYTES] without a modulo.
  assign key_byte = key_r[8*KEY_BYTES-1 -: 8];
  assign i_next   = i + 8'd1;
  assign j_ksa    = j + s_rddata + key_byte;
  assign j_prga   = j + s_rddata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rdy       <= 1'b1;
      pt_addr   <= 8'd0;
      ct_addr   <= 8'd0;
      ct_wrdata <= 8'd0;
      ct_wren   <= 1'b0;
      s_addr    <= 8'd0;
      s_wrdata  <= 8'd0;
      s_wren    <= 1'b0;
      i         <= 8'd0;
      j         <= 8'd0;
      k         <= 9'd0;
      si        <= 8'd0;
      sj        <= 8'd0;
      len       <= 8'd0;
      key_r     <= '0;
`ifdef ARC4_ENC_DROP_EN
      dropping  <= 1'b0;
`endif
    end else begin
      // Strobes are single-cycle pulses unless a state re-asserts them.
      s_wren  <= 1'b0;
      ct_wren <= 1'b0;

      case (state)
        S_IDLE: begin
          if (en) begin
            key_r <= key;
            rdy   <= 1'b0;
            i     <= 8'd0;
            j     <= 8'd0;
            k     <= 9'd0;
            state <= S_INIT;
          end
        end

        S_INIT: begin
          s_addr   <= i;
          s_wrdata <= i;
          s_wren   <= 1'b1;
          i        <= i_next;
          if (i == 8'hFF) state <= S_KSA_RD_I;
        end

        S_KSA_RD_I: begin
          s_addr <= i;
          state  <= S_KSA_WAIT_I;
        end

        S_KSA_WAIT_I: state <= S_KSA_RD_J;

        S_KSA_RD_J: begin
          si     <= s_rddata;
          j      <= j_ksa;
          s_addr <= j_ksa;
          key_r  <= (key_r << 8) | (key_r >> (8*(KEY_BYTES-1)));
          state  <= S_KSA_WAIT_J;
        end

        S_KSA_WAIT_J: state <= S_KSA_WR_I;

        // When i==j both reads returned the same value, so the second write
        // stores the original byte again.
        S_KSA_WR_I: begin
          s_addr   <= i;
          s_wrdata <= s_rddata;
          s_wren   <= 1'b1;
          state    <= S_KSA_WR_J;
        end

        S_KSA_WR_J: begin
          s_addr   <= j;
          s_wrdata <= si;
          s_wren   <= 1'b1;
          i        <= i_next;
          if (i == 8'hFF) begin
`ifdef ARC4_ENC_DROP_EN
            j        <= 8'd0;
            k        <= 9'd0;
            dropping <= 1'b1;
            state    <= S_PRGA_RD_I;
`else
            state    <= S_LEN_RD;
`endif
          end else begin
            state <= S_KSA_RD_I;
          end
        end

        S_LEN_RD: begin
          pt_addr <= 8'd0;
          state   <= S_LEN_WAIT;
        end

        S_LEN_WAIT: state <= S_LEN_WR;

        S_LEN_WR: begin
          len       <= pt_rddata;
          ct_addr   <= 8'd0;
          ct_wrdata <= pt_rddata;
          ct_wren   <= 1'b1;
          k         <= 9'd1;
`ifndef ARC4_ENC_DROP_EN
          i         <= 8'd0;
          j         <= 8'd0;
`endif
          if (pt_rddata == 8'd0) state <= S_DONE;
          else                   state <= S_PRGA_RD_I;
        end

        S_PRGA_RD_I: begin
          i      <= i_next;
          s_addr <= i_next;
          state  <= S_PRGA_WAIT_I;
        end

        S_PRGA_WAIT_I: state <= S_PRGA_RD_J;

        S_PRGA_RD_J: begin
          si     <= s_rddata;
          j      <= j_prga;
          s_addr <= j_prga;
          state  <= S_PRGA_WAIT_J;
        end

        S_PRGA_WAIT_J: state <= S_PRGA_WR_I;

        S_PRGA_WR_I: begin
          sj       <= s_rddata;
          s_addr   <= i;
          s_wrdata <= s_rddata;
          s_wren   <= 1'b1;
          state    <= S_PRGA_WR_J;
        end

        S_PRGA_WR_J: begin
          s_addr   <= j;
          s_wrdata <= si;
          s_wren   <= 1'b1;
`ifdef ARC4_ENC_DROP_EN
          if (dropping) begin
            if (k[7:0] == 8'hFF) begin
              dropping <= 1'b0;
              state    <= S_LEN_RD;
            end else begin
              k     <= k + 9'd1;
              state <= S_PRGA_RD_I;
            end
          end else begin
            state <= S_PRGA_RD_PAD;
          end
`else
          state <= S_PRGA_RD_PAD;
`endif
        end

        // After the swap S[i]+S[j] equals old S[j]+old S[i].
        S_PRGA_RD_PAD: begin
          s_addr  <= si + sj;
          pt_addr <= k[7:0];
          state   <= S_PRGA_WAIT_PAD;
        end

        S_PRGA_WAIT_PAD: state <= S_PRGA_WR_CT;

        S_PRGA_WR_CT: begin
          ct_addr   <= k[7:0];
          ct_wrdata <= pt_rddata ^ s_rddata;
          ct_wren   <= 1'b1;
          if (k == {1'b0, len}) begin
            state <= S_DONE;
          end else begin
            k     <= k + 9'd1;
            state <= S_PRGA_RD_I;
          end
        end

        S_DONE: begin
          rdy   <= 1'b1;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arc4_enc.sv
// tb_arc4_enc: self-checking bench for arc4_enc with behavioural memories and
// a software RC4 reference model.
module tb_arc4_enc;

  localparam int KEY_BYTES = 3;
`ifdef ARC4_ENC_DROP_EN
  localparam int DROP = 256;
`else
  localparam int DROP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [7:0]  pt_addr, pt_rddata;
  logic [7:0]  ct_addr, ct_wrdata;
  logic        ct_wren;
  logic [7:0]  s_addr, s_rddata, s_wrdata;
  logic        s_wren;

  arc4_enc #(.KEY_BYTES(KEY_BYTES)) dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy), .key(key),
    .pt_addr(pt_addr), .pt_rddata(pt_rddata),
    .ct_addr(ct_addr), .ct_wrdata(ct_wrdata), .ct_wren(ct_wren),
    .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren)
  );

  always #5 clk = ~clk;

  logic [7:0] pt_mem [256];
  logic [7:0] ct_mem [256];
  logic [7:0] s_mem  [256];

  always @(posedge clk) begin
    pt_rddata <= pt_mem[pt_addr];
    s_rddata  <= s_mem[s_addr];
    if (s_wren)  s_mem[s_addr]   <= s_wrdata;
    if (ct_wren) ct_mem[ct_addr] <= ct_wrdata;
  end

  logic mon_clear = 1'b0;
  int   ct_wr_count;
  int   accepts;
  int   ct_hits [256];

  always @(posedge clk) begin
    if (mon_clear) begin
      ct_wr_count <= 0;
      accepts     <= 0;
      for (int a = 0; a < 256; a++) ct_hits[a] <= 0;
    end else begin
      if (ct_wren) begin
        ct_wr_count      <= ct_wr_count + 1;
        ct_hits[ct_addr] <= ct_hits[ct_addr] + 1;
      end
      if (!rst && rdy && en) accepts <= accepts + 1;
    end
  end

  int checks   = 0;
  int failures = 0;

  // Reference model: textbook RC4 on plain integer arrays.
  logic [7:0] ks  [512];
  int         m_s [256];

  task automatic model_rc4(input logic [23:0] k, input int drop, input int n);
    int s [256];
    int i, j, t, kb;
    for (int x = 0; x < 256; x++) s[x] = x;
    j = 0;
    for (int x = 0; x < 256; x++) begin
      kb = int'(k[8*(KEY_BYTES-1-(x % KEY_BYTES)) +: 8]);
      j = (j + s[x] + kb) % 256;
      t = s[x]; s[x] = s[j]; s[j] = t;
    end
    i = 0; j = 0;
    for (int c = 0; c < drop + n; c++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      if (c >= drop) ks[c - drop] = 8'(s[(s[i] + s[j]) % 256]);
    end
    m_s = s;
  endtask

  task automatic clear_mon();
    mon_clear = 1'b1;
    @(negedge clk);
    mon_clear = 1'b0;
  endtask

  task automatic load_random_pt(input int len);
    pt_mem[0] = 8'(len);
    for (int a = 1; a < 256; a++) pt_mem[a] = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_rdy(input string name);
    int budget = 0;
    while (rdy !== 1'b1 && budget < 20000) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (rdy !== 1'b1) begin
      failures++;
      $display("FAIL %s_timeout rdy=%b required=1", name, rdy);
    end
  endtask

  task automatic run_enc(input logic [23:0] k, input string name);
    clear_mon();
    wait_rdy({name, "_idle"});
    key = k;
    en  = 1'b1;
    @(negedge clk);
    en  = 1'b0;
    checks++;
    if (rdy !== 1'b0) begin
      failures++;
      $display("FAIL %s_accept rdy=%b required=0", name, rdy);
    end
    wait_rdy(name);
  endtask

  // Compares ct[0..len] with the model keystream applied to pt_mem.
  task automatic check_ct(input int len, input string name);
    int bad = 0;
    int first = -1;
    for (int a = 0; a <= len; a++) begin
      logic [7:0] exp_b;
      exp_b = (a == 0) ? pt_mem[0] : (pt_mem[a] ^ ks[a-1]);
      if (ct_mem[a] !== exp_b) begin
        bad++;
        if (first < 0) first = a;
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s_ct bad_bytes=%0d first_addr=%0d got=%h required=%h", name, bad, first,
               ct_mem[first], (first == 0) ? pt_mem[0] : (pt_mem[first] ^ ks[first-1]));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; key = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (rdy !== 1'b1 || s_wren !== 1'b0 || ct_wren !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl rdy=%b s_wren=%b ct_wren=%b required=1,0,0", rdy, s_wren, ct_wren);
    end
    checks++;
    if ({pt_addr, ct_addr, s_addr, ct_wrdata, s_wrdata} !== 40'd0) begin
      failures++;
      $display("FAIL reset_bus pt=%h ct=%h s=%h ctd=%h sd=%h required=0",
               pt_addr, ct_addr, s_addr, ct_wrdata, s_wrdata);
    end
  endtask

  task automatic load_known_pt();
    logic [7:0] vec [10];
    vec = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    for (int a = 0; a < 10; a++) pt_mem[a] = vec[a];
  endtask

`ifndef ARC4_ENC_DROP_EN
  task automatic test_known_vector();
    logic [7:0] exp_ct [10];
    int bad;
    exp_ct = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    load_known_pt();
    run_enc(24'h4B6579, "known");
    for (int a = 0; a < 10; a++) begin
      checks++;
      if (ct_mem[a] !== exp_ct[a]) begin
        failures++;
        $display("FAIL known_ct%0d got=%h required=%h", a, ct_mem[a], exp_ct[a]);
      end
    end
    checks++;
    if (ct_wr_count != 10) begin
      failures++;
      $display("FAIL known_wr_count got=%0d required=10", ct_wr_count);
    end
    model_rc4(24'h4B6579, 0, 9);
    bad = 0;
    for (int a = 0; a < 256; a++) if (s_mem[a] !== 8'(m_s[a])) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL known_final_s bad_entries=%0d required=0", bad);
    end
  endtask
`endif

  task automatic test_round_trip();
    int bad = 0;
    load_random_pt(200);
    run_enc(24'h1E4600, "round");
    model_rc4(24'h1E4600, DROP, 200);
    for (int a = 1; a <= 200; a++) if ((ct_mem[a] ^ ks[a-1]) !== pt_mem[a]) bad++;
    checks++;
    if (ct_mem[0] !== 8'd200 || bad != 0) begin
      failures++;
      $display("FAIL round_trip len=%0d bad_bytes=%0d required len=200 bad=0", ct_mem[0], bad);
    end
  endtask

  task automatic test_len_zero();
    load_random_pt(0);
    run_enc(24'($urandom), "len0");
    checks++;
    if (ct_wr_count != 1 || ct_hits[0] != 1) begin
      failures++;
      $display("FAIL len0_writes count=%0d hits0=%0d required=1,1", ct_wr_count, ct_hits[0]);
    end
    checks++;
    if (ct_mem[0] !== 8'h00) begin
      failures++;
      $display("FAIL len0_ct0 got=%h required=00", ct_mem[0]);
    end
  endtask

  task automatic test_len_max();
    int bad = 0;
    load_random_pt(255);
    run_enc(24'hFFFFFF, "len255");
    model_rc4(24'hFFFFFF, DROP, 255);
    for (int a = 0; a < 256; a++) if (ct_hits[a] != 1) bad++;
    checks++;
    if (ct_wr_count != 256 || bad != 0) begin
      failures++;
      $display("FAIL len255_writes count=%0d bad_addrs=%0d required=256,0", ct_wr_count, bad);
    end
    check_ct(255, "len255");
  endtask

  task automatic test_reset_mid();
    int low_cycles = 0;
    load_known_pt();
    clear_mon();
    key = 24'h4B6579; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (256 + 300) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (rdy !== 1'b1 || s_wren !== 1'b0 || ct_wren !== 1'b0) begin
      failures++;
      $display("FAIL midrst_ctrl rdy=%b s_wren=%b ct_wren=%b required=1,0,0", rdy, s_wren, ct_wren);
    end
    // Fresh run with an en pulse in the middle that must be ignored.
    clear_mon();
    key = 24'h4B6579; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (100) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    wait_rdy("midrst");
    repeat (40) begin
      @(negedge clk);
      if (rdy !== 1'b1) low_cycles++;
    end
    checks++;
    if (accepts != 1 || low_cycles != 0) begin
      failures++;
      $display("FAIL busy_en accepts=%0d rdy_low_cycles=%0d required=1,0", accepts, low_cycles);
    end
    model_rc4(24'h4B6579, DROP, 9);
    check_ct(9, "midrst");
  endtask

  task automatic test_back_to_back();
    logic [23:0] k1, k2;
    int budget = 0;
    k1 = 24'($urandom);
    k2 = k1 ^ 24'h5A5A5A;
    load_random_pt(5);
    clear_mon();
    key = k1; en = 1'b1;
    @(negedge clk);
    key = k2;
    while (rdy !== 1'b1 && budget < 20000) begin
      @(negedge clk);
      budget++;
    end
    @(negedge clk);
    checks++;
    if (rdy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_reaccept rdy=%b required=0", rdy);
    end
    en = 1'b0;
    wait_rdy("b2b");
    checks++;
    if (accepts != 2 || ct_wr_count != 12) begin
      failures++;
      $display("FAIL b2b_counts accepts=%0d writes=%0d required=2,12", accepts, ct_wr_count);
    end
    model_rc4(k2, DROP, 5);
    check_ct(5, "b2b");
  endtask

`ifdef ARC4_ENC_DROP_EN
  task automatic test_drop();
    pt_mem[0] = 8'h01;
    pt_mem[1] = 8'h00;
    run_enc(24'h4B6579, "drop");
    model_rc4(24'h4B6579, 0, 257);
    checks++;
    if (ct_mem[1] !== ks[256]) begin
      failures++;
      $display("FAIL drop_ct1 got=%h required=%h", ct_mem[1], ks[256]);
    end
    checks++;
    if (ct_wr_count != 2 || ct_hits[0] != 1 || ct_hits[1] != 1 || ct_mem[0] !== 8'h01) begin
      failures++;
      $display("FAIL drop_writes count=%0d hits0=%0d hits1=%0d ct0=%h required=2,1,1,01",
               ct_wr_count, ct_hits[0], ct_hits[1], ct_mem[0]);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifndef ARC4_ENC_DROP_EN
    test_known_vector();
`else
    test_drop();
`endif
    test_round_trip();
    test_len_zero();
    test_len_max();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
